// File: rtl/calc1_req_queue_pkg.sv
// Shared types, command codes and the legality helper for the calc1 request queue.
package calc1_req_queue_pkg;

  localparam int DATA_W = 32;
  localparam int CMD_W  = 4;
  localparam int TAG_W  = 2;

  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_OK   = 2'b01,
    RESP_OVF  = 2'b10,
    RESP_INV  = 2'b11
  } resp_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OP2  = 1'b1
  } cap_state_e;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [TAG_W-1:0]  tag;
  } req_t;

  function automatic logic cmd_is_legal(input logic [CMD_W-1:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

endpackage

// File: rtl/calc1_req_queue_if.sv
// Port-side request bus plus ALU-side handshake of the calc1 request queue.
interface calc1_req_queue_if #(
  parameter int CNT_W = 8
);
  import calc1_req_queue_pkg::*;

  logic [CMD_W-1:0]  cmd_in;
  logic [DATA_W-1:0] data_in;
  logic              alu_valid;
  logic              alu_ready;
  logic [CMD_W-1:0]  alu_cmd;
  logic [DATA_W-1:0] alu_op1;
  logic [DATA_W-1:0] alu_op2;
  logic [TAG_W-1:0]  alu_tag;
  logic [1:0]        rej_resp;
  logic              fifo_full;
  logic [CNT_W-1:0]  drop_cnt;

  // Requester/ALU side of the bus.
  modport master (
    output cmd_in, data_in, alu_ready,
    input  alu_valid, alu_cmd, alu_op1, alu_op2, alu_tag, rej_resp, fifo_full, drop_cnt
  );

  // Request queue side of the bus.
  modport slave (
    input  cmd_in, data_in, alu_ready,
    output alu_valid, alu_cmd, alu_op1, alu_op2, alu_tag, rej_resp, fifo_full, drop_cnt
  );

endinterface

// File: rtl/calc1_req_queue_fifo.sv
// Synchronous FIFO: storage, wrapping pointers, occupancy count, registered full/empty.
// The caller never pushes into a full FIFO unless it pops in the same cycle.
module calc1_req_queue_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_empty;
  logic             r_full;
  logic [CNT_W-1:0] w_count_nxt;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count + CNT_W'(i_push) - CNT_W'(i_pop);
  end

  // Entry storage.
  // NOTE: the data array has no reset; validity is tracked by the count, so clearing it buys nothing.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers, count and the registered status flags; DEPTH is a power of 2 so pointers wrap naturally.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = r_empty;
  assign o_full  = r_full;

endmodule

// File: rtl/calc1_req_queue.sv
// calc1 request front-end: two-cycle capture FSM, command validation, sequence tags,
// drop counting and a small FIFO feeding the ALU over valid/ready.
module calc1_req_queue
  import calc1_req_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  calc1_req_queue_if.slave   io_port
);

  cap_state_e        r_state;
  cap_state_e        w_state_nxt;
  logic              w_cap_cmd;
  logic              w_cap_op2;
  logic [CMD_W-1:0]  r_cmd;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_op2;
  logic              r_done;
  logic [TAG_W-1:0]  r_tag;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic              w_legal;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_empty;
  logic              w_full;
  req_t              w_entry;
  req_t              w_head;

  // Capture FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and capture strobes; cmd_in is ignored while collecting operand2.
  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cap_cmd   = 1'b0;
    w_cap_op2   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (io_port.cmd_in != '0) begin
          w_cap_cmd   = 1'b1;
          w_state_nxt = S_OP2;
        end
      end
      S_OP2: begin
        w_cap_op2   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request holding registers; r_done marks the completion cycle after operand2.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cmd  <= '0;
      r_op1  <= '0;
      r_op2  <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_cap_cmd) begin
        r_cmd <= io_port.cmd_in;
        r_op1 <= io_port.data_in;
      end
      if (w_cap_op2) r_op2 <= io_port.data_in;
      r_done <= w_cap_op2;
    end
  end

  // Completion decision: a pop in the same cycle frees a slot for the push.
  always_comb begin
    w_legal = cmd_is_legal(r_cmd);
    w_pop   = !w_empty && io_port.alu_ready;
    w_push  = r_done && w_legal && (!w_full || w_pop);
    w_drop  = r_done && w_legal && w_full && !w_pop;
  end

  assign w_entry = '{cmd: r_cmd, op1: r_op1, op2: r_op2, tag: r_tag};

  // Sequence tag advances only on an accepted push; drop counter saturates.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tag      <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_tag <= r_tag + TAG_W'(1);
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  calc1_req_queue_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata (w_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Head fields are forced to zero while nothing is presented, so stale storage never leaks out.
  assign io_port.alu_valid = !w_empty;
  assign io_port.alu_cmd   = w_empty ? '0 : w_head.cmd;
  assign io_port.alu_op1   = w_empty ? '0 : w_head.op1;
  assign io_port.alu_op2   = w_empty ? '0 : w_head.op2;
  assign io_port.alu_tag   = w_empty ? '0 : w_head.tag;
  assign io_port.rej_resp  = (r_done && (!w_legal || w_drop)) ? RESP_INV : RESP_NONE;
  assign io_port.fifo_full = w_full;
  assign io_port.drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_calc1_req_queue.sv
// Self-checking bench for calc1_req_queue: directed scenarios plus random traffic,
// scored by a queue-based reference model evaluated mid-cycle.
module tb_calc1_req_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    int          due;
  } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   rnd_ready = 1'b0;

  // Reference model state.
  pend_t       pending[$];
  logic [69:0] exp_q[$];
  int          m_tag = 0;
  int          m_drop = 0;

  calc1_req_queue_if #(.CNT_W(CNT_W)) ifc ();

  calc1_req_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .io_port (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor/scoreboard: compares the current cycle, then advances the model.
  bit          mon_pop;
  bit          mon_push;
  logic [1:0]  mon_rej;
  logic [69:0] mon_entry;
  pend_t       mon_req;

  always @(negedge clk) begin
    if (rst) begin
      pending.delete();
      exp_q.delete();
      m_tag  = 0;
      m_drop = 0;
    end else begin
      check("alu_valid", 72'(ifc.alu_valid), 72'(exp_q.size() != 0));
      check("fifo_full", 72'(ifc.fifo_full), 72'(exp_q.size() == DEPTH));
      check("drop_cnt", 72'(ifc.drop_cnt), 72'(m_drop));
      if (exp_q.size() != 0)
        check("alu_head", 72'({ifc.alu_cmd, ifc.alu_op1, ifc.alu_op2, ifc.alu_tag}), 72'(exp_q[0]));
      mon_pop  = (exp_q.size() != 0) && (ifc.alu_ready === 1'b1);
      mon_push = 1'b0;
      mon_rej  = 2'b00;
      if (pending.size() != 0 && pending[0].due == cyc) begin
        mon_req = pending.pop_front();
        if (!(mon_req.cmd inside {4'd1, 4'd2, 4'd5, 4'd6})) begin
          mon_rej = 2'b11;
        end else if (exp_q.size() < DEPTH || mon_pop) begin
          mon_push  = 1'b1;
          mon_entry = {mon_req.cmd, mon_req.op1, mon_req.op2, 2'(m_tag)};
          m_tag     = (m_tag + 1) % 4;
        end else begin
          mon_rej = 2'b11;
          if (m_drop < 255) m_drop++;
        end
      end
      check("rej_resp", 72'(ifc.rej_resp), 72'(mon_rej));
      if (mon_pop)  void'(exp_q.pop_front());
      if (mon_push) exp_q.push_back(mon_entry);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ifc.cmd_in  = 4'd0;
      ifc.data_in = $urandom;
      if (rnd_ready) ifc.alu_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Two-cycle request; c2 is what cmd_in shows during the operand2 cycle.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c2);
    @(posedge clk); #1;
    ifc.cmd_in  = c;
    ifc.data_in = a;
    if (rnd_ready) ifc.alu_ready = 1'($urandom_range(0, 1));
    pending.push_back('{cmd: c, op1: a, op2: b, due: cyc + 2});
    @(posedge clk); #1;
    ifc.cmd_in  = c2;
    ifc.data_in = b;
    if (rnd_ready) ifc.alu_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    ifc.cmd_in = 4'd0;
    ifc.alu_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [3:0] rand_cmd();
    logic [3:0] legal_set [4];
    legal_set = '{4'd1, 4'd2, 4'd5, 4'd6};
    if ($urandom_range(0, 9) < 7) return legal_set[$urandom_range(0, 3)];
    return 4'($urandom_range(1, 15));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit drained;
    ifc.cmd_in    = 4'd0;
    ifc.data_in   = 32'd0;
    ifc.alu_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_alu_valid", 72'(ifc.alu_valid), 72'(0));
    check("rst_rej_resp", 72'(ifc.rej_resp), 72'(0));
    check("rst_fifo_full", 72'(ifc.fifo_full), 72'(0));
    check("rst_drop_cnt", 72'(ifc.drop_cnt), 72'(0));
    check("rst_alu_cmd", 72'(ifc.alu_cmd), 72'(0));
    rst = 1'b0;

    // Walking add with the ALU always ready.
    ifc.alu_ready = 1'b1;
    for (int i = 0; i < 31; i++) issue(4'd1, 32'd1 << i, 32'd0, 4'd0);
    idle(4);

    // Illegal command is answered locally.
    issue(4'd3, 32'd5, 32'd7, 4'd0);
    idle(4);

    // A command shown during the operand2 cycle is ignored.
    issue(4'd1, 32'hAAAA_0001, 32'h5555_0002, 4'd2);
    idle(4);

    // Fill with ALU stalled, fifth request dropped, then drain in order.
    do_reset();
    for (int i = 0; i < 5; i++) issue(4'd2, 32'(100 + i), 32'(200 + i), 4'd0);
    idle(2);
    check("fill_fifo_full", 72'(ifc.fifo_full), 72'(1));
    check("fill_drop_cnt", 72'(ifc.drop_cnt), 72'(1));
    ifc.alu_ready = 1'b1;
    idle(6);
    ifc.alu_ready = 1'b0;

    // Full FIFO with a pop on the completion cycle accepts the push.
    for (int i = 0; i < 4; i++) issue(4'd5, 32'(300 + i), 32'(i), 4'd0);
    idle(2);
    issue(4'd6, 32'hDEAD_BEEF, 32'h0000_0003, 4'd0);
    @(posedge clk); #1;
    ifc.cmd_in = 4'd0;
    ifc.alu_ready = 1'b1;
    @(posedge clk); #1;
    ifc.alu_ready = 1'b0;
    check("pop_push_full", 72'(ifc.fifo_full), 72'(1));
    check("pop_push_drop", 72'(ifc.drop_cnt), 72'(1));

    // Drop counter saturation.
    for (int i = 0; i < 300; i++) issue(4'd1, $urandom, $urandom, 4'd0);
    idle(2);
    check("drop_saturate", 72'(ifc.drop_cnt), 72'(255));
    ifc.alu_ready = 1'b1;
    idle(6);
    ifc.alu_ready = 1'b0;

    // Reset during operand2 with two entries queued.
    issue(4'd1, 32'd11, 32'd12, 4'd0);
    issue(4'd2, 32'd21, 32'd22, 4'd0);
    idle(2);
    @(posedge clk); #1;
    ifc.cmd_in  = 4'd1;
    ifc.data_in = 32'd31;
    @(posedge clk); #1;
    ifc.cmd_in  = 4'd0;
    ifc.data_in = 32'd32;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 72'(ifc.alu_valid), 72'(0));
    check("mid_rst_drop", 72'(ifc.drop_cnt), 72'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);

    // Random traffic with random back-pressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      issue(rand_cmd(), $urandom, $urandom, 4'($urandom_range(0, 15)));
      idle($urandom_range(0, 2));
    end
    rnd_ready = 1'b0;

    // Drain everything still expected.
    ifc.alu_ready = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 100 && !drained; i++) begin
      idle(1);
      drained = (exp_q.size() == 0) && (pending.size() == 0);
    end
    check("drain_done", 72'(drained), 72'(1));
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
